// File: rtl/cmp_bist_sequencer_if.sv
// rtl/cmp_bist_sequencer_if.sv - operand/response bus between the BIST sequencer and the comparator
interface cmp_bist_sequencer_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             gt_in;
  logic             eq_in;
  logic             lt_in;

  modport master (
    output a_out,
    output b_out,
    input  gt_in,
    input  eq_in,
    input  lt_in
  );

  modport slave (
    input  a_out,
    input  b_out,
    output gt_in,
    output eq_in,
    output lt_in
  );
endinterface

// File: rtl/cmp_bist_sequencer.sv
// rtl/cmp_bist_sequencer.sv - exhaustive self-test sweep of a WIDTH-bit magnitude comparator
module cmp_bist_sequencer #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cmp_bist_sequencer_if.master cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     fail_count,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b,
  output logic                 any_fail
);
  localparam int IW = 2 * WIDTH;
  localparam int FW = IW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [FW-1:0]    fail_count_q, fail_count_d;
  logic [WIDTH-1:0] first_fail_a_q, first_fail_a_d;
  logic [WIDTH-1:0] first_fail_b_q, first_fail_b_d;
  logic             any_fail_q, any_fail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_cur, b_cur;
  logic [2:0]       exp_resp;
  logic             mismatch;

  always_comb begin
    a_cur    = idx_q[IW-1:WIDTH];
    b_cur    = idx_q[WIDTH-1:0];
    exp_resp = {a_cur > b_cur, a_cur == b_cur, a_cur < b_cur};
    mismatch = exp_resp != {cmp.gt_in, cmp.eq_in, cmp.lt_in};

    state_d        = state_q;
    idx_d          = idx_q;
    settle_d       = settle_q;
    fail_count_d   = fail_count_q;
    first_fail_a_d = first_fail_a_q;
    first_fail_b_d = first_fail_b_q;
    any_fail_d     = any_fail_q;
    busy_d         = busy_q;
    done_d         = done_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = APPLY;
          idx_d          = '0;
          settle_d       = '0;
          fail_count_d   = '0;
          first_fail_a_d = '0;
          first_fail_b_d = '0;
          any_fail_d     = 1'b0;
          busy_d         = 1'b1;
          done_d         = 1'b0;
        end
      end
      APPLY: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + FW'(1);
          if (!any_fail_q) begin
            first_fail_a_d = a_cur;
            first_fail_b_d = b_cur;
            any_fail_d     = 1'b1;
          end
        end
        // Last vector stays on the bus after the sweep ends.
        if (idx_q == {IW{1'b1}}) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      settle_q       <= '0;
      fail_count_q   <= '0;
      first_fail_a_q <= '0;
      first_fail_b_q <= '0;
      any_fail_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      settle_q       <= settle_d;
      fail_count_q   <= fail_count_d;
      first_fail_a_q <= first_fail_a_d;
      first_fail_b_q <= first_fail_b_d;
      any_fail_q     <= any_fail_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cmp.a_out    = idx_q[IW-1:WIDTH];
  assign cmp.b_out    = idx_q[WIDTH-1:0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = done_q && (fail_count_q == '0);
  assign fail_count   = fail_count_q;
  assign first_fail_a = first_fail_a_q;
  assign first_fail_b = first_fail_b_q;
  assign any_fail     = any_fail_q;
endmodule

// File: tb/tb_cmp_bist_sequencer.sv
// tb/tb_cmp_bist_sequencer.sv - directed vector bench for cmp_bist_sequencer
module tb_cmp_bist_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start, start3;
  logic [1:0] mode;

  logic busy, done, pass, any_fail;
  logic [4:0] fail_count;
  logic [1:0] ffa, ffb;
  logic busy3, done3, pass3, any_fail3;
  logic [4:0] fail_count3;
  logic [1:0] ffa3, ffb3;

  int total = 0;
  int bad = 0;

  cmp_bist_sequencer_if #(.WIDTH(2)) bus ();
  cmp_bist_sequencer_if #(.WIDTH(2)) bus3 ();

  cmp_bist_sequencer #(.WIDTH(2), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp(bus),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_a(ffa), .first_fail_b(ffb), .any_fail(any_fail)
  );

  cmp_bist_sequencer #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmp(bus3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fail_count3),
    .first_fail_a(ffa3), .first_fail_b(ffb3), .any_fail(any_fail3)
  );

  always #5 clk = ~clk;

  // mode 0: good comparator, 1: eq stuck at 0, 2: gt/lt swapped
  always_comb begin
    bus.gt_in = (bus.a_out > bus.b_out);
    bus.eq_in = (bus.a_out == bus.b_out);
    bus.lt_in = (bus.a_out < bus.b_out);
    if (mode == 2'd1) bus.eq_in = 1'b0;
    if (mode == 2'd2) begin
      bus.gt_in = (bus.a_out < bus.b_out);
      bus.lt_in = (bus.a_out > bus.b_out);
    end
    bus3.gt_in = (bus3.a_out > bus3.b_out);
    bus3.eq_in = (bus3.a_out == bus3.b_out);
    bus3.lt_in = (bus3.a_out < bus3.b_out);
  end

  typedef struct {
    logic [1:0] mode;
    int         fails;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pass;
    logic       any;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_sweep(input int pulse_at, output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == pulse_at) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int run, changes, bad_runs;
    logic [3:0] prev;

    vecs[0] = '{mode: 2'd0, fails: 0,  fa: 2'd0, fb: 2'd0, pass: 1'b1, any: 1'b0};
    vecs[1] = '{mode: 2'd1, fails: 4,  fa: 2'd0, fb: 2'd0, pass: 1'b0, any: 1'b1};
    vecs[2] = '{mode: 2'd2, fails: 12, fa: 2'd0, fb: 2'd1, pass: 1'b0, any: 1'b1};

    rst = 1'b1; start = 1'b0; start3 = 1'b0; mode = 2'd0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_any_fail", any_fail, 0);
    chk("rst_a_out", bus.a_out, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      mode = vecs[i].mode;
      pulse_start();
      chk($sformatf("v%0d_busy_after_start", i), busy, 1);
      run_sweep(-1, cyc);
      chk($sformatf("v%0d_busy_cycles", i), cyc, 32);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].pass);
      chk($sformatf("v%0d_fail_count", i), fail_count, vecs[i].fails);
      chk($sformatf("v%0d_any_fail", i), any_fail, vecs[i].any);
      chk($sformatf("v%0d_first_a", i), ffa, vecs[i].fa);
      chk($sformatf("v%0d_first_b", i), ffb, vecs[i].fb);
      chk($sformatf("v%0d_last_vec", i), {bus.a_out, bus.b_out}, 15);
      step();
    end

    // Second start at cycle 7 must be ignored.
    mode = 2'd1;
    pulse_start();
    run_sweep(7, cyc);
    chk("ign_busy_cycles", cyc, 32);
    chk("ign_done", done, 1);
    chk("ign_fail_count", fail_count, 4);
    chk("ign_first_b", ffb, 0);
    chk("ign_pass", pass, 0);
    step();

    // Asynchronous reset mid-sweep.
    pulse_start();
    repeat (9) step();
    chk("mid_pre_fail_count", fail_count, 1);
    chk("mid_pre_a_out", bus.a_out, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_fail_count", fail_count, 0);
    chk("mid_rst_any_fail", any_fail, 0);
    chk("mid_rst_a_out", bus.a_out, 0);
    chk("mid_rst_done", done, 0);
    step();
    rst = 1'b0;
    mode = 2'd0;
    step();
    chk("mid_idle_busy", busy, 0);
    pulse_start();
    run_sweep(-1, cyc);
    chk("mid_busy_cycles", cyc, 32);
    chk("mid_pass", pass, 1);
    chk("mid_fail_count", fail_count, 0);

    // SETTLE=3: each vector held 4 cycles.
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    cyc = 0; run = 0; changes = 0; bad_runs = 0;
    prev = {bus3.a_out, bus3.b_out};
    while (busy3 && cyc < 400) begin
      if ({bus3.a_out, bus3.b_out} == prev) run++;
      else begin
        if (run != 4) bad_runs++;
        changes++;
        run = 1;
        prev = {bus3.a_out, bus3.b_out};
      end
      cyc++;
      step();
    end
    chk("s3_busy_cycles", cyc, 64);
    chk("s3_changes", changes, 15);
    chk("s3_bad_runs", bad_runs, 0);
    chk("s3_last_run", run, 4);
    chk("s3_pass", pass3, 1);
    chk("s3_done", done3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmp_bist_sequencer.md
# cmp_bist_sequencer

On-chip self-test sequencer for the 2-bit magnitude comparator. It drives every A/B operand pair into the comparator and samples the comparator's gt/eq/lt responses. Each response is checked against the arithmetic result, and the block reports pass/fail, a mismatch count and the first failing vector. It sits beside the comparator inside the project top: `a_out`/`b_out` feed the comparator's A/B inputs (ui_in[1:0]/ui_in[3:2] in the bench mapping), and `gt_in`/`eq_in`/`lt_in` come from its outputs (uo_out[0]/[1]/[2]).

## Interface
Parameters:
- `WIDTH`, default 2: operand width. The sweep covers N = 2^(2*WIDTH) vectors (16 at default).
- `SETTLE`, default 1, must be ≥ 1: cycles each vector is held before its response is sampled.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a sweep. Accepted in IDLE or DONE only.
- `a_out`  out  WIDTH  operand A driven to the comparator.
- `b_out`  out  WIDTH  operand B driven to the comparator.
- `gt_in`  in  1  comparator response, A>B.
- `eq_in`  in  1  comparator response, A==B.
- `lt_in`  in  1  comparator response, A<B.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted start or reset.
- `pass`  out  1  equals `done` AND (`fail_count` == 0).
- `fail_count`  out  2*WIDTH+1  number of mismatching vectors in the current or last sweep.
- `first_fail_a`  out  WIDTH  A operand of the first mismatching vector.
- `first_fail_b`  out  WIDTH  B operand of the first mismatching vector.
- `any_fail`  out  1  high once any mismatch has been recorded in this sweep.

## Operation
- State machine states: IDLE, APPLY, CHECK, DONE.
- Vector index `idx` has width 2*WIDTH. `a_out` = idx[2*WIDTH-1:WIDTH] and `b_out` = idx[WIDTH-1:0]. Sweep order is therefore (A,B) = (0,0), (0,1), …, (0,3), (1,0), …, (3,3).
- IDLE or DONE with `start`=1 → APPLY. On that edge:
  - `idx` = 0, settle counter = 0, `fail_count` = 0, `any_fail` = 0, `first_fail_a`/`first_fail_b` = 0.
  - `done` = 0, `busy` = 1.
- APPLY: settle counter increments each cycle. When it reaches SETTLE-1, go to CHECK and clear the counter.
- CHECK: compute the expected response as gt = (A>B), eq = (A==B), lt = (A<B), unsigned compare. A mismatch is any of the three bits differing from `gt_in`/`eq_in`/`lt_in`.
- On the edge leaving CHECK, when a mismatch is present:
  - `fail_count` increments.
  - If `any_fail` was 0, capture `first_fail_a`/`first_fail_b` from the current vector and set `any_fail`.
- Leaving CHECK when idx ≠ N-1: `idx` increments and the next state is APPLY.
- Leaving CHECK when idx = N-1: the next state is DONE. `idx` stays at N-1, so `a_out`/`b_out` hold the last vector.
- DONE: `busy` = 0, `done` = 1. All results hold until a new `start` is accepted or reset.
- `start` while in APPLY or CHECK is ignored. It has no effect on `idx` or the results.
- Responses are sampled only in CHECK. Values on `gt_in`/`eq_in`/`lt_in` during APPLY are don't-care.
- `fail_count` cannot overflow, because its maximum value N fits in 2*WIDTH+1 bits.

## Timing
- Every output is a register, with no combinational paths from inputs to outputs. Exception: `pass` is a combinational AND of two registered terms.
- Reset values: state IDLE; `a_out` = `b_out` = 0; `busy` = `done` = `pass` = `any_fail` = 0; `fail_count` = 0; `first_fail_a` = `first_fail_b` = 0.
- Reset asserted at any point mid-sweep forces the reset values immediately, without waiting for a clock edge. After release, the block waits in IDLE for `start`.
- A vector occupies SETTLE+1 cycles: SETTLE cycles in APPLY plus 1 in CHECK.
- `busy` is high for exactly N*(SETTLE+1) cycles after the start edge. That is 32 cycles at the defaults.
- `done` rises on the edge after the final CHECK cycle.
- New operands appear on `a_out`/`b_out` on the edge leaving CHECK. The comparator therefore sees each vector for SETTLE+1 full cycles before its response is sampled at the end of CHECK.
- `start` held high continuously: one sweep runs, and then a new sweep starts on the first DONE cycle. In that case `done` is high for exactly 1 cycle.

## Test plan
- Correct comparator model, defaults, start pulse → `busy` high for 32 cycles, then `done` = 1, `pass` = 1, `fail_count` = 0, `any_fail` = 0.
- Model with `eq_in` stuck at 0 → `done` with `pass` = 0, `fail_count` = 4, first failure (A=0, B=0).
- Model with `gt_in` and `lt_in` swapped → `fail_count` = 12, first failure (A=0, B=1).
- `start` pulsed again at cycle 7 of a sweep → ignored; `done` still rises at cycle 32 and results match the single-start run.
- `rst` asserted at cycle 10 mid-sweep → all outputs return to 0 immediately. A subsequent start completes a full 32-cycle sweep with correct results.
- SETTLE = 3, correct model → `busy` lasts 64 cycles. Each (`a_out`, `b_out`) value is stable for 4 cycles, and `pass` = 1.
